// File: rtl/board_pkg.sv
// Board-level shared types and constants.
// Contents used by the ROM fetch path:
//   rom_fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, DONE)
//   ROM_LINE_BYTES    : bytes per SDRAM burst line (8)
//   ROM_TAG_W         : line tag width, rom_addr[19:3] (17)
//   rom_word_sel      : picks 16-bit word n out of a little-endian 64-bit line
package board_pkg;

   localparam int unsigned ROM_LINE_BYTES = 8;
   localparam int unsigned ROM_TAG_W      = 17;
   localparam int unsigned ROM_LINE_W     = 64;
   localparam int unsigned ROM_WORD_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } rom_fetch_state_t;

   // Word n sits at bits [16n+15:16n].
   function automatic logic [ROM_WORD_W-1:0] rom_word_sel(input logic [ROM_LINE_W-1:0] line,
                                                          input logic [1:0]            idx);
      return line[{idx, 4'b0000} +: ROM_WORD_W];
   endfunction

endpackage

// File: rtl/rom_line_buffer.sv
// Single-line ROM buffer: one 64-bit line, its 17-bit tag and a valid bit.
// Ports:
//   clk, reset        : clock, async active-high reset
//   lookup_tag/word   : tag and word index of the incoming CPU read
//   invalidate        : clears valid; also forces a miss on the same-cycle lookup
//   fill_en/tag/data  : line write from a completed SDRAM burst
//   hit_c, hit_word_c : combinational hit flag and selected word
module rom_line_buffer
   import board_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ROM_TAG_W-1:0]  lookup_tag,
   input  logic [1:0]            lookup_word,
   input  logic                  invalidate,
   input  logic                  fill_en,
   input  logic [ROM_TAG_W-1:0]  fill_tag,
   input  logic [ROM_LINE_W-1:0] fill_data,
   output logic                  hit_c,
   output logic [ROM_WORD_W-1:0] hit_word_c
);

   logic                  valid_q;
   logic [ROM_TAG_W-1:0]  tag_q;
   logic [ROM_LINE_W-1:0] data_q;

   // Line storage; invalidate wins over a fill landing in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         if (invalidate) begin
            valid_q <= 1'b0;
         end else if (fill_en) begin
            valid_q <= 1'b1;
         end
         if (fill_en) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
         end
      end
   end

   assign hit_c      = valid_q & ~invalidate & (tag_q == lookup_tag);
   assign hit_word_c = rom_word_sel(data_q, lookup_word);

endmodule

// File: rtl/rom_fetch_bridge.sv
// CPU ROM read to SDRAM 64-bit burst bridge with req/ack toggle handshake.
// Optional single-line buffer compiled in with `define ROM_LINE_BUFFER_EN.
// Ports:
//   clk, reset            : clock, async active-high reset (shared with SDRAM controller)
//   rd_strobe             : one-cycle start of a CPU read cycle
//   cpu_rom_memrq         : ROM select; strobes without it are ignored
//   rom_addr[19:0]        : ROM byte address (bit 0 ignored)
//   invalidate            : clears the line buffer (ignored without the buffer)
//   dout[15:0]            : read data, holds between reads
//   rdy                   : low while the CPU must wait
//   sdr_addr[SDR_AW-1:0]  : 8-byte aligned burst address
//   sdr_req / sdr_ack     : request / acknowledge toggles
//   sdr_data[63:0]        : burst data, little-endian words
module rom_fetch_bridge
   import board_pkg::*;
#(
   parameter int unsigned       SDR_AW   = 25,
   parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_strobe,
   input  logic                  cpu_rom_memrq,
   input  logic [19:0]           rom_addr,
   input  logic                  invalidate,
   output logic [ROM_WORD_W-1:0] dout,
   output logic                  rdy,
   output logic [SDR_AW-1:0]     sdr_addr,
   output logic                  sdr_req,
   input  logic                  sdr_ack,
   input  logic [ROM_LINE_W-1:0] sdr_data
);

   localparam int unsigned LINE_OFS_W = $clog2(ROM_LINE_BYTES);
   localparam int unsigned WADDR_W    = 19;

   rom_fetch_state_t      state_q, state_d;
   logic [WADDR_W-1:0]    lat_addr_q, lat_addr_d;
   logic [ROM_WORD_W-1:0] dout_d;
   logic                  rdy_d;
   logic                  sdr_req_d;
   logic [SDR_AW-1:0]     sdr_addr_d;
   logic                  fill_en_c;
   logic                  hit_c;
   logic [ROM_WORD_W-1:0] hit_word_c;
   logic [19:0]           line_byte_c;
   logic [SDR_AW-1:0]     req_addr_c;

   // Line-aligned byte address of the latched read, rebased and wrapped to SDR_AW bits.
   assign line_byte_c = {lat_addr_q[WADDR_W-1:2], LINE_OFS_W'(0)};
   assign req_addr_c  = ROM_BASE + SDR_AW'(line_byte_c);

`ifdef ROM_LINE_BUFFER_EN
   rom_line_buffer u_line_buffer (
      .clk         (clk),
      .reset       (reset),
      .lookup_tag  (rom_addr[19:3]),
      .lookup_word (rom_addr[2:1]),
      .invalidate  (invalidate),
      .fill_en     (fill_en_c),
      .fill_tag    (lat_addr_q[WADDR_W-1:2]),
      .fill_data   (sdr_data),
      .hit_c       (hit_c),
      .hit_word_c  (hit_word_c)
   );

   logic unused_c;
   assign unused_c = rom_addr[0];
`else
   assign hit_c      = 1'b0;
   assign hit_word_c = '0;

   logic unused_c;
   assign unused_c = ^{invalidate, fill_en_c, rom_addr[0]};
`endif

   // Fetch FSM: next state and next register values.
   always_comb begin
      state_d    = state_q;
      lat_addr_d = lat_addr_q;
      dout_d     = dout;
      rdy_d      = rdy;
      sdr_req_d  = sdr_req;
      sdr_addr_d = sdr_addr;
      fill_en_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rd_strobe && cpu_rom_memrq) begin
               lat_addr_d = rom_addr[19:1];
               rdy_d      = 1'b0;
               if (hit_c) begin
                  dout_d  = hit_word_c;
                  state_d = DONE;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            sdr_addr_d = req_addr_c;
            sdr_req_d  = ~sdr_req;
            state_d    = WAIT;
         end
         WAIT: begin
            if (sdr_ack == sdr_req) begin
               dout_d    = rom_word_sel(sdr_data, lat_addr_q[1:0]);
               fill_en_c = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            rdy_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         lat_addr_q <= '0;
         dout       <= '0;
         rdy        <= 1'b1;
         sdr_req    <= 1'b0;
         sdr_addr   <= '0;
      end else begin
         state_q    <= state_d;
         lat_addr_q <= lat_addr_d;
         dout       <= dout_d;
         rdy        <= rdy_d;
         sdr_req    <= sdr_req_d;
         sdr_addr   <= sdr_addr_d;
      end
   end

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Bench for rom_fetch_bridge: two instances (ROM_BASE 0 and a wrapping base),
// a toggle-ack SDRAM responder per instance, a transaction-level reference
// model and a per-cycle compare process.
module tb_rom_fetch_bridge;

   localparam int unsigned       AW     = 25;
   localparam logic [AW-1:0]     BASE_B = 25'h1FF_FFF8;

   logic          clk;
   logic          reset;
   logic          rd_strobe;
   logic          cpu_rom_memrq;
   logic [19:0]   rom_addr;
   logic          invalidate;
   logic [63:0]   sdr_data;

   logic [15:0]   dout_a, dout_b;
   logic          rdy_a, rdy_b;
   logic [AW-1:0] sdr_addr_a, sdr_addr_b;
   logic          sdr_req_a, sdr_req_b;
   logic          sdr_ack_a, sdr_ack_b;

   int            n_lat;
   int            cnt_a, cnt_b;

   logic          exp_rdy;
   logic [15:0]   exp_dout;
   logic          exp_req;
   logic [AW-1:0] exp_addr_a, exp_addr_b;
   int            pin_sel;
   bit            chk_en;

   bit            m_valid;
   logic [16:0]   m_tag;
   logic [63:0]   m_line;

   int            n_total;
   int            n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rom_fetch_bridge #(.SDR_AW(AW), .ROM_BASE('0)) u_dut_a (
      .clk(clk), .reset(reset), .rd_strobe(rd_strobe), .cpu_rom_memrq(cpu_rom_memrq),
      .rom_addr(rom_addr), .invalidate(invalidate), .dout(dout_a), .rdy(rdy_a),
      .sdr_addr(sdr_addr_a), .sdr_req(sdr_req_a), .sdr_ack(sdr_ack_a), .sdr_data(sdr_data)
   );

   rom_fetch_bridge #(.SDR_AW(AW), .ROM_BASE(BASE_B)) u_dut_b (
      .clk(clk), .reset(reset), .rd_strobe(rd_strobe), .cpu_rom_memrq(cpu_rom_memrq),
      .rom_addr(rom_addr), .invalidate(invalidate), .dout(dout_b), .rdy(rdy_b),
      .sdr_addr(sdr_addr_b), .sdr_req(sdr_req_b), .sdr_ack(sdr_ack_b), .sdr_data(sdr_data)
   );

   // SDRAM responder: ack becomes visible n_lat-1 cycles after the request toggle,
   // giving n_lat WAIT cycles in the bridge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sdr_ack_a <= 1'b0;
         cnt_a     <= 0;
      end else if (sdr_req_a != sdr_ack_a) begin
         if (cnt_a >= n_lat - 2) begin
            sdr_ack_a <= sdr_req_a;
            cnt_a     <= 0;
         end else begin
            cnt_a <= cnt_a + 1;
         end
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sdr_ack_b <= 1'b0;
         cnt_b     <= 0;
      end else if (sdr_req_b != sdr_ack_b) begin
         if (cnt_b >= n_lat - 2) begin
            sdr_ack_b <= sdr_req_b;
            cnt_b     <= 0;
         end else begin
            cnt_b <= cnt_b + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   // Per-cycle compare against the model, plus literal pins at chosen cycles.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("rdy_a",  64'(rdy_a),      64'(exp_rdy));
         chk("rdy_b",  64'(rdy_b),      64'(exp_rdy));
         chk("req_a",  64'(sdr_req_a),  64'(exp_req));
         chk("req_b",  64'(sdr_req_b),  64'(exp_req));
         chk("addr_a", 64'(sdr_addr_a), 64'(exp_addr_a));
         chk("addr_b", 64'(sdr_addr_b), 64'(exp_addr_b));
         if (exp_rdy) begin
            chk("dout_a", 64'(dout_a), 64'(exp_dout));
            chk("dout_b", 64'(dout_b), 64'(exp_dout));
         end
         case (pin_sel)
            1: begin
               chk("pin_miss_dout", 64'(dout_a),     64'h4444);
               chk("pin_miss_addr", 64'(sdr_addr_a), 64'h0);
               chk("pin_miss_rdy8", 64'(rdy_a),      64'h1);
               chk("pin_miss_req",  64'(sdr_req_a),  64'h1);
            end
            2: chk("pin_miss_rdy7", 64'(rdy_a), 64'h0);
            3: begin
               chk("pin_reread_dout", 64'(dout_a), 64'h2222);
`ifdef ROM_LINE_BUFFER_EN
               chk("pin_hit_no_req", 64'(sdr_req_a), 64'h1);
`else
               chk("pin_reread_req", 64'(sdr_req_a), 64'h0);
`endif
            end
            4: begin
               chk("pin_wrap_addr", 64'(sdr_addr_b), 64'h0);
               chk("pin_wrap_dout", 64'(dout_b),     64'h89AB);
            end
            5: begin
               chk("pin_rst_rdy",  64'(rdy_a),     64'h1);
               chk("pin_rst_dout", 64'(dout_a),    64'h0);
               chk("pin_rst_req",  64'(sdr_req_a), 64'h0);
            end
            6: chk("pin_after_abort_req", 64'(sdr_req_a), 64'h1);
            7: begin
`ifdef ROM_LINE_BUFFER_EN
               chk("pin_inval_req", 64'(sdr_req_a), 64'h0);
`else
               chk("pin_inval_req", 64'(sdr_req_a), 64'h1);
`endif
            end
            default: ;
         endcase
      end
   end

   // One CPU read; model decides hit/miss, latency, word and request address.
   task automatic do_read(input logic [19:0] addr, input int lat, input logic [63:0] data,
                          input bit inv, input bit extra, input int pin_pre, input int pin_end);
      bit          hit;
      int          lat_cyc;
      logic [63:0] src;
      logic [15:0] word;
      logic [19:0] line;
      line = addr & 20'hFFFF8;
`ifdef ROM_LINE_BUFFER_EN
      hit = m_valid && (m_tag == addr[19:3]) && !inv;
`else
      hit = 1'b0;
`endif
      src     = hit ? m_line : data;
      word    = 16'((src >> (16 * int'(addr[2:1]))) & 64'hFFFF);
      lat_cyc = hit ? 2 : lat + 3;

      n_lat         = lat;
      sdr_data      = data;
      invalidate    = inv;
      rom_addr      = addr;
      cpu_rom_memrq = 1'b1;
      rd_strobe     = 1'b1;
      pin_sel       = 0;
      for (int c = 1; c <= lat_cyc; c++) begin
         @(posedge clk); #1;
         rd_strobe = extra && (c == 1);
         if (extra && c == 1) rom_addr = 20'($urandom);
         if (!hit && c == 2) begin
            exp_req    = ~exp_req;
            exp_addr_a = AW'(line);
            exp_addr_b = AW'((longint'(BASE_B) + longint'(line)) % (longint'(1) << AW));
         end
         exp_rdy = (c == lat_cyc);
         if (c == lat_cyc) exp_dout = word;
         pin_sel = (c == lat_cyc) ? pin_end : ((c == lat_cyc - 1) ? pin_pre : 0);
      end
      if (!hit) begin
         m_valid = !inv;
         m_tag   = addr[19:3];
         m_line  = data;
      end
      if (inv) m_valid = 1'b0;
      @(posedge clk); #1;
      invalidate = 1'b0;
      pin_sel    = 0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      chk_en  = 1'b0;
      pin_sel = 0;
      reset   = 1'b1;
      rd_strobe = 1'b0;
      cpu_rom_memrq = 1'b0;
      rom_addr = '0;
      invalidate = 1'b0;
      sdr_data = '0;
      n_lat = 5;
      exp_rdy = 1'b1;
      exp_dout = '0;
      exp_req = 1'b0;
      exp_addr_a = '0;
      exp_addr_b = '0;
      m_valid = 1'b0;
      m_tag = '0;
      m_line = '0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      pin_sel = 5;
      @(posedge clk); #1 pin_sel = 0;

      // Strobe without ROM select: nothing must happen.
      rom_addr = 20'h00006;
      cpu_rom_memrq = 1'b0;
      rd_strobe = 1'b1;
      @(posedge clk); #1 rd_strobe = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      do_read(20'h00006, 5, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 2, 1);
      do_read(20'h00002, 3, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 0, 3);

      invalidate = 1'b1;
      m_valid = 1'b0;
      @(posedge clk); #1 invalidate = 1'b0;
      do_read(20'h00002, 3, 64'h4444_3333_2222_1111, 1'b0, 1'b0, 0, 7);

      do_read(20'h0000A, 4, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0, 4);

      for (int i = 0; i < 40; i++) begin
         logic [19:0] a;
         a = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 31));
         do_read(a, int'($urandom_range(2, 6)), {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 0, 0);
      end

      // Reset in the middle of WAIT aborts the read.
      n_lat = 10;
      sdr_data = 64'hAAAA_BBBB_CCCC_DDDD;
      rom_addr = 20'h12340;
      cpu_rom_memrq = 1'b1;
      rd_strobe = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         rd_strobe = 1'b0;
         exp_rdy = 1'b0;
         if (c == 2) begin
            exp_req    = ~exp_req;
            exp_addr_a = AW'(20'h12340);
            exp_addr_b = AW'((longint'(BASE_B) + longint'(20'h12340)) % (longint'(1) << AW));
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      exp_rdy = 1'b1;
      exp_req = 1'b0;
      exp_dout = '0;
      exp_addr_a = '0;
      exp_addr_b = '0;
      m_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      do_read(20'h12346, 4, 64'h1357_2468_9ABC_DEF0, 1'b0, 1'b0, 0, 6);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rom_fetch_bridge.md
# rom_fetch_bridge

Sits between the CPU address translator and the SDRAM controller. It turns a translated CPU ROM read (`cpu_rom_memrq` plus 20-bit `rom_addr`) into a 64-bit SDRAM burst request using req/ack toggle signalling, and returns the selected 16-bit word. It holds the CPU in wait states through `rdy` until the data is valid. An optional one-line buffer serves repeated reads from the same 8-byte line without touching SDRAM.

## Interface
Parameters:
- `SDR_AW`, default 25: SDRAM byte address width.
- `ROM_BASE`, default 25'h0: SDRAM byte offset of CPU ROM region.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_strobe`  in  1  one-cycle pulse marking the start of a CPU read cycle.
- `cpu_rom_memrq`  in  1  decoded ROM select from the address translator.
- `rom_addr`  in  20  translated ROM byte address; bit 0 is ignored.
- `invalidate`  in  1  clears the line buffer (held high during ROM download).
- `dout`  out  16  read data.
- `rdy`  out  1  high means the CPU may complete the cycle; low inserts wait states.
- `sdr_addr`  out  SDR_AW  burst address, 8-byte aligned.
- `sdr_req`  out  1  request toggle.
- `sdr_ack`  in  1  acknowledge toggle; data is valid when `sdr_ack` equals `sdr_req`.
- `sdr_data`  in  64  burst data; word n is at bits [16n+15:16n], little-endian.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `rd_strobe & cpu_rom_memrq` latches `rom_addr[19:1]` and drives `rdy` low.
  - If the line buffer hits (EN builds only), go to DONE.
  - Otherwise go to REQ.
- `rd_strobe` without `cpu_rom_memrq` is ignored.
- REQ: set `sdr_addr = ROM_BASE + {rom_addr[19:3],3'b0}`, toggle `sdr_req`, go to WAIT.
- WAIT: stay until `sdr_ack == sdr_req`. Then:
  - `dout` takes word `rom_addr[2:1]` of `sdr_data`.
  - In EN builds, the line is stored with tag `rom_addr[19:3]` and the valid bit set.
  - Go to DONE.
- DONE: `rdy` goes high and the block returns to IDLE.
- `rd_strobe` while not in IDLE is ignored. No queueing is done; the CPU is stalled by `rdy` during that time.
- The SDRAM address is computed modulo 2^SDR_AW.
- `dout` holds its last value between reads.
- `invalidate`:
  - Clears the valid bit immediately.
  - An in-flight miss completes normally but does not set valid if `invalidate` is high in the capture cycle.
  - A hit lookup in the same cycle as `invalidate` is treated as a miss.

## Timing
- Reset values:
  - state IDLE
  - `rdy` = 1
  - `dout` = 0
  - `sdr_req` = 0
  - `sdr_addr` = 0
  - line valid = 0
- The SDRAM controller shares `reset`, so its `sdr_ack` also resets to 0.
- Miss latency:
  - cycle 0: strobe
  - cycle 1: REQ, `sdr_req` toggles at the end of the cycle
  - WAIT for N cycles until ack
  - data captured in the ack cycle
  - `rdy` high one cycle after capture
- Total miss latency is N+3 cycles from strobe to `rdy`.
- Hit latency: strobe in cycle 0, DONE in cycle 1, `rdy` high in cycle 2. `dout` is valid whenever `rdy` rises.
- `rdy` falls registered, one cycle after strobe. The CPU must sample `rdy` no earlier than cycle 1.
- Reset mid-WAIT aborts the transaction. A late ack from the old transaction cannot occur because the controller is reset too.

## Configuration
- `ROM_LINE_BUFFER_EN` defined:
  - A 64-bit data register, 17-bit tag and valid bit are compiled in.
  - Hits take 2 cycles.
- `ROM_LINE_BUFFER_EN` not defined:
  - No buffer logic is built; every read goes to SDRAM.
  - `invalidate` is accepted and ignored.

## Structure
- `board_pkg` gains:
  - the `rom_fetch_state_t` enum (IDLE, REQ, WAIT, DONE)
  - the `ROM_LINE_BYTES` = 8 constant
  - the `ROM_TAG_W` = 17 constant
- Sub-module `rom_line_buffer` holds the tag, valid bit and data, and provides the hit compare and word select. It is instantiated only under `ROM_LINE_BUFFER_EN`.

## Test plan
- Reset check: after reset release, `rdy`=1, `dout`=0, `sdr_req`=0; an idle strobe with `cpu_rom_memrq`=0 causes no toggle.
- Miss read: read `rom_addr`=20'h00006 with model latency 5 and `sdr_data`=64'h4444_3333_2222_1111.
  - `sdr_addr`=0 and `sdr_req` toggles once.
  - `rdy` rises 8 cycles after the strobe with `dout`=16'h4444.
- Buffer hit (EN): read 20'h00002 after the previous miss.
  - No `sdr_req` toggle.
  - `rdy` high in cycle 2 with `dout`=16'h2222.
- Invalidate: raise `invalidate`, then read 20'h00002 → a new SDRAM request is issued. Non-EN build: every read of the same address toggles `sdr_req`.
- Base and wrap: with `ROM_BASE`=25'h1FF_FFF8, read 20'h0000A → `sdr_addr`=25'h000_0000 (modulo wrap) and word 1 is returned.
- Reset mid-WAIT: assert `reset` while waiting.
  - State returns to IDLE with `rdy`=1.
  - The next miss completes with a single toggle.
